// File: rtl/wb_arb_pkg.sv
// Shared state type and helpers for the Wishbone round-robin arbiter.
// The optional timeout feature is selected by WB_ARB_TIMEOUT_EN in wb_rr_arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} arb_state_t;

  localparam int MAX_PACKED_W = 512;
  localparam int MAX_SLICE_W  = 64;

  function automatic int idxWidth(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Callers zero-extend the packed bus to MAX_PACKED_W and truncate the result.
  function automatic logic [MAX_SLICE_W-1:0] sliceOf(input logic [MAX_PACKED_W-1:0] bus,
                                                     input int idx, input int width);
    logic [MAX_PACKED_W-1:0] shifted;
    shifted = bus >> (idx * width);
    return shifted[MAX_SLICE_W-1:0];
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: returns the first set request strictly above
// the last grant, wrapping around, plus a flag saying whether any request exists.
module rr_priority_encoder #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  localparam logic [IW:0] N_VAL = (IW+1)'(N);

  logic [IW:0]  w_start;
  logic [N-1:0] w_rotated;
  logic [IW:0]  w_pos;
  logic [IW:0]  w_sum;

  assign w_start = {1'b0, i_last} + 1'b1;

  // Shifting the doubled vector puts the search start at bit 0.
  assign w_rotated = N'({i_req, i_req} >> w_start);

  always_comb begin
    w_pos   = '0;
    o_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rotated[k]) begin
        w_pos   = (IW+1)'(k);
        o_valid = 1'b1;
      end
    end
  end

  assign w_sum = w_start + w_pos;
  assign o_idx = (w_sum >= N_VAL) ? IW'(w_sum - N_VAL) : IW'(w_sum);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave port among NUM_MASTERS masters.
// Define WB_ARB_TIMEOUT_EN to add the stalled-strobe timeout, ABORT state and m_err_o.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int BUS_WIDTH      = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*BUS_WIDTH-1:0]  m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
  input  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_sel_i,
  output logic [DATA_WIDTH-1:0]             m_data_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            gnt_o,
  output logic                              cyc_o,
  output logic                              stb_o,
  output logic                              we_o,
  output logic [BUS_WIDTH-1:0]              adr_o,
  output logic [DATA_WIDTH-1:0]             data_o,
  output logic [BE_WIDTH-1:0]               sel_o,
  input  logic [DATA_WIDTH-1:0]             data_i,
  input  logic                              ack_i
);

  localparam int GW = idxWidth(NUM_MASTERS);

  arb_state_t             r_state, w_nextState;
  logic [GW-1:0]          r_grant, w_nextGrant;
  logic [GW-1:0]          r_lastGrant, w_nextLast;
  logic [NUM_MASTERS-1:0] w_req, w_gntVec;
  logic [GW-1:0]          w_encIdx;
  logic                   w_encValid;
  logic                   w_gCyc, w_gStb, w_gWe;
  logic [BUS_WIDTH-1:0]   w_gAdr;
  logic [DATA_WIDTH-1:0]  w_gData;
  logic [BE_WIDTH-1:0]    w_gSel;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_count, w_nextCount;
`endif

  assign w_req = m_cyc_i & m_stb_i;

  rr_priority_encoder #(
    .N  (NUM_MASTERS),
    .IW (GW)
  ) u_encoder (
    .i_req   (w_req),
    .i_last  (r_lastGrant),
    .o_idx   (w_encIdx),
    .o_valid (w_encValid)
  );

  assign w_gntVec = NUM_MASTERS'(1) << r_grant;
  assign w_gCyc   = m_cyc_i[r_grant];
  assign w_gStb   = m_stb_i[r_grant];
  assign w_gWe    = m_we_i[r_grant];
  assign w_gAdr   = BUS_WIDTH'(sliceOf(MAX_PACKED_W'(m_adr_i), int'(r_grant), BUS_WIDTH));
  assign w_gData  = DATA_WIDTH'(sliceOf(MAX_PACKED_W'(m_data_i), int'(r_grant), DATA_WIDTH));
  assign w_gSel   = BE_WIDTH'(sliceOf(MAX_PACKED_W'(m_sel_i), int'(r_grant), BE_WIDTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_lastGrant <= GW'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      r_count     <= '0;
`endif
    end else begin
      r_state     <= w_nextState;
      r_grant     <= w_nextGrant;
      r_lastGrant <= w_nextLast;
`ifdef WB_ARB_TIMEOUT_EN
      r_count     <= w_nextCount;
`endif
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextGrant = r_grant;
    w_nextLast  = r_lastGrant;
`ifdef WB_ARB_TIMEOUT_EN
    w_nextCount = '0;
`endif
    m_data_o = data_i;
    m_ack_o  = '0;
    m_err_o  = '0;
    gnt_o    = '0;
    cyc_o    = 1'b0;
    stb_o    = 1'b0;
    we_o     = 1'b0;
    adr_o    = '0;
    data_o   = '0;
    sel_o    = '0;
    case (r_state)
      IDLE: begin
        if (w_encValid) begin
          w_nextState = BUSY;
          w_nextGrant = w_encIdx;
        end
      end
      BUSY: begin
        gnt_o   = w_gntVec;
        cyc_o   = w_gCyc;
        stb_o   = w_gStb;
        we_o    = w_gWe;
        adr_o   = w_gAdr;
        data_o  = w_gData;
        sel_o   = w_gSel;
        m_ack_o = w_gntVec & {NUM_MASTERS{ack_i & w_gStb}};
        if (!w_gCyc) begin
          w_nextState = IDLE;
          w_nextLast  = r_grant;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (ack_i || !w_gStb) begin
          w_nextCount = '0;
        end else if (r_count == CNT_LAST) begin
          m_err_o     = w_gntVec;
          w_nextState = ABORT;
        end else begin
          w_nextCount = r_count + 1'b1;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      // The aborted master keeps the grant until it lets go of cyc.
      ABORT: begin
        gnt_o  = w_gntVec;
        we_o   = w_gWe;
        adr_o  = w_gAdr;
        data_o = w_gData;
        sel_o  = w_gSel;
        if (!w_gCyc) begin
          w_nextState = IDLE;
          w_nextLast  = r_grant;
        end
      end
`endif
      default: w_nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: vector table, corner-case sequences
// and a randomized run against a per-master ownership model.
module tb_wb_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  mCyc, mStb, mWe;
  logic [N*AW-1:0] mAdr;
  logic [N*DW-1:0] mDataW;
  logic [N*BW-1:0] mSel;
  logic [DW-1:0] mDataR;
  logic [N-1:0]  mAck, mErr, gnt;
  logic          cycO, stbO, weO;
  logic [AW-1:0] adrO;
  logic [DW-1:0] dataO;
  logic [BW-1:0] selO;
  logic [DW-1:0] slvData;
  logic          slvAck;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] adrArr [N];
  logic [DW-1:0] datArr [N];
  logic [BW-1:0] selArr [N];

  logic          curRst, curAck;
  logic [N-1:0]  curCyc, curStb, curWe;
  logic [DW-1:0] curDin;

  wb_rr_arbiter #(
    .NUM_MASTERS    (N),
    .BUS_WIDTH      (AW),
    .DATA_WIDTH     (DW),
    .BE_WIDTH       (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .m_cyc_i  (mCyc),
    .m_stb_i  (mStb),
    .m_we_i   (mWe),
    .m_adr_i  (mAdr),
    .m_data_i (mDataW),
    .m_sel_i  (mSel),
    .m_data_o (mDataR),
    .m_ack_o  (mAck),
    .m_err_o  (mErr),
    .gnt_o    (gnt),
    .cyc_o    (cycO),
    .stb_o    (stbO),
    .we_o     (weO),
    .adr_o    (adrO),
    .data_o   (dataO),
    .sel_o    (selO),
    .data_i   (slvData),
    .ack_i    (slvAck)
  );

  // Drives one cycle's inputs; per-master address/data/select come from the arrays.
  task automatic applyStimulus(input logic r, input logic [N-1:0] cyc, input logic [N-1:0] stb,
                               input logic [N-1:0] we, input logic ack, input logic [DW-1:0] din);
    rst = r; mCyc = cyc; mStb = stb; mWe = we; slvAck = ack; slvData = din;
    for (int k = 0; k < N; k++) begin
      mAdr[k*AW +: AW]   = adrArr[k];
      mDataW[k*DW +: DW] = datArr[k];
      mSel[k*BW +: BW]   = selArr[k];
    end
    curRst = r; curCyc = cyc; curStb = stb; curWe = we; curAck = ack; curDin = din;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, '0, '0, '0, 1'b0, '0);
    step();
  endtask

  // Reference model: who owns the bus, who owned it last, how long the strobe stalled.
  int mOwner, mLast, mStall;
  bit mAbort;
  logic [N-1:0]  eGnt, eAck, eErr;
  logic          eCyc, eStb, eWe;
  logic [AW-1:0] eAdr;
  logic [DW-1:0] eDat;
  logic [BW-1:0] eSel;

  task automatic modelReset();
    mOwner = -1; mLast = N - 1; mStall = 0; mAbort = 1'b0;
  endtask

  task automatic modelOutputs();
    eGnt = '0; eAck = '0; eErr = '0; eCyc = 1'b0; eStb = 1'b0; eWe = 1'b0;
    eAdr = '0; eDat = '0; eSel = '0;
    if (mOwner >= 0) begin
      eGnt[mOwner] = 1'b1;
      eWe  = curWe[mOwner];
      eAdr = adrArr[mOwner];
      eDat = datArr[mOwner];
      eSel = selArr[mOwner];
      if (!mAbort) begin
        eCyc = curCyc[mOwner];
        eStb = curStb[mOwner];
        eAck[mOwner] = curAck & curStb[mOwner];
`ifdef WB_ARB_TIMEOUT_EN
        if (curCyc[mOwner] && curStb[mOwner] && !curAck && mStall == TO - 1) eErr[mOwner] = 1'b1;
`endif
      end
    end
  endtask

  task automatic modelStep();
    if (curRst) begin
      modelReset();
    end else if (mOwner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c = (mLast + k) % N;
        if (mOwner < 0 && curCyc[c] && curStb[c]) mOwner = c;
      end
      mStall = 0;
      mAbort = 1'b0;
    end else if (!curCyc[mOwner]) begin
      mLast  = mOwner;
      mOwner = -1;
    end else if (!mAbort) begin
      if (eErr != '0) mAbort = 1'b1;
      else if (curStb[mOwner] && !curAck) mStall++;
      else mStall = 0;
    end
  endtask

  typedef struct {
    string         name;
    logic          rst;
    logic [N-1:0]  cyc, stb, we;
    logic [AW-1:0] adr1;
    logic [DW-1:0] dat1;
    logic [BW-1:0] sel1;
    logic          ack;
    logic [DW-1:0] din;
    logic [N-1:0]  eGnt;
    logic [2:0]    eCtl;
    logic [AW-1:0] eAdr;
    logic [DW-1:0] eDat;
    logic [BW-1:0] eSel;
    logic [N-1:0]  eAck;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [N-1:0] ackedLast, prevGnt, rCyc, rStb, rWe;
    logic [N-1:0] grants [$];
    int zeroRun;

    vecs[0]  = '{"reset",             1, 2'b00, 2'b00, 2'b00, 5'h00, 32'h0, 4'h0, 0, 32'h0,
                 2'b00, 3'b000, 5'h00, 32'h0, 4'h0, 2'b00};
    vecs[1]  = '{"m1 request",        0, 2'b10, 2'b10, 2'b10, 5'h0A, 32'hDEADBEEF, 4'hF, 0, 32'h0,
                 2'b00, 3'b000, 5'h00, 32'h0, 4'h0, 2'b00};
    vecs[2]  = '{"m1 write ack",      0, 2'b10, 2'b10, 2'b10, 5'h0A, 32'hDEADBEEF, 4'hF, 1, 32'h0,
                 2'b10, 3'b111, 5'h0A, 32'hDEADBEEF, 4'hF, 2'b10};
    vecs[3]  = '{"m1 release",        0, 2'b00, 2'b00, 2'b00, 5'h0A, 32'hDEADBEEF, 4'hF, 0, 32'h0,
                 2'b10, 3'b000, 5'h0A, 32'hDEADBEEF, 4'hF, 2'b00};
    vecs[4]  = '{"idle stray ack",    0, 2'b00, 2'b00, 2'b00, 5'h0A, 32'hDEADBEEF, 4'hF, 1, 32'hCAFEF00D,
                 2'b00, 3'b000, 5'h00, 32'h0, 4'h0, 2'b00};
    vecs[5]  = '{"m0 request",        0, 2'b01, 2'b01, 2'b00, 5'h0A, 32'hDEADBEEF, 4'hF, 0, 32'h0,
                 2'b00, 3'b000, 5'h00, 32'h0, 4'h0, 2'b00};
    vecs[6]  = '{"m0 ack no stb",     0, 2'b01, 2'b00, 2'b00, 5'h0A, 32'hDEADBEEF, 4'hF, 1, 32'h0,
                 2'b01, 3'b100, 5'h03, 32'h12345678, 4'h3, 2'b00};
    vecs[7]  = '{"m0 ack with stb",   0, 2'b01, 2'b01, 2'b00, 5'h0A, 32'hDEADBEEF, 4'hF, 1, 32'h55AA55AA,
                 2'b01, 3'b110, 5'h03, 32'h12345678, 4'h3, 2'b01};
    vecs[8]  = '{"m0 release m1 req", 0, 2'b10, 2'b10, 2'b10, 5'h0A, 32'hDEADBEEF, 4'hF, 0, 32'h0,
                 2'b01, 3'b000, 5'h03, 32'h12345678, 4'h3, 2'b00};
    vecs[9]  = '{"rearbitrate",       0, 2'b10, 2'b10, 2'b10, 5'h0A, 32'hDEADBEEF, 4'hF, 0, 32'h0,
                 2'b00, 3'b000, 5'h00, 32'h0, 4'h0, 2'b00};
    vecs[10] = '{"m1 granted",        0, 2'b10, 2'b10, 2'b10, 5'h0A, 32'hDEADBEEF, 4'hF, 0, 32'h0,
                 2'b10, 3'b111, 5'h0A, 32'hDEADBEEF, 4'hF, 2'b00};
    vecs[11] = '{"m1 done",           0, 2'b00, 2'b00, 2'b00, 5'h0A, 32'hDEADBEEF, 4'hF, 0, 32'h0,
                 2'b10, 3'b000, 5'h0A, 32'hDEADBEEF, 4'hF, 2'b00};
    vecs[12] = '{"idle",              0, 2'b00, 2'b00, 2'b00, 5'h0A, 32'hDEADBEEF, 4'hF, 1, 32'h0,
                 2'b00, 3'b000, 5'h00, 32'h0, 4'h0, 2'b00};

    adrArr[0] = 5'h03; datArr[0] = 32'h12345678; selArr[0] = 4'h3;
    adrArr[1] = 5'h00; datArr[1] = 32'h0;        selArr[1] = 4'h0;
    applyStimulus(1'b1, '0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;

    // Vector table: single-master write, stray acks, hand-over between masters.
    for (int i = 0; i < 13; i++) begin
      adrArr[1] = vecs[i].adr1; datArr[1] = vecs[i].dat1; selArr[1] = vecs[i].sel1;
      applyStimulus(vecs[i].rst, vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].ack, vecs[i].din);
      #2;
      checkOutput($sformatf("%s gnt", vecs[i].name), gnt, vecs[i].eGnt);
      checkOutput($sformatf("%s ctl", vecs[i].name), {cycO, stbO, weO}, vecs[i].eCtl);
      checkOutput($sformatf("%s adr", vecs[i].name), adrO, vecs[i].eAdr);
      checkOutput($sformatf("%s data", vecs[i].name), dataO, vecs[i].eDat);
      checkOutput($sformatf("%s sel", vecs[i].name), selO, vecs[i].eSel);
      checkOutput($sformatf("%s ack", vecs[i].name), mAck, vecs[i].eAck);
      checkOutput($sformatf("%s err", vecs[i].name), mErr, 2'b00);
      checkOutput($sformatf("%s rdata", vecs[i].name), mDataR, vecs[i].din);
      step();
    end

    // Contention: masters drop cyc for one cycle after each ack.
    doReset();
    ackedLast = '0; prevGnt = '0; zeroRun = 0;
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1'b0, ~ackedLast, ~ackedLast, '0, 1'b1, '0);
      #2;
      if (gnt == '0) zeroRun++;
      else if (prevGnt == '0) begin
        grants.push_back(gnt);
        checkOutput($sformatf("fairness idle gap %0d", grants.size()), zeroRun, 1);
        zeroRun = 0;
      end
      prevGnt = gnt;
      ackedLast = mAck;
      step();
    end
    checkOutput("fairness grant count", (grants.size() >= 4) ? 1 : 0, 1);
    for (int g = 0; g < 4 && g < grants.size(); g++)
      checkOutput($sformatf("fairness grant %0d", g), grants[g], (g % 2 == 0) ? 2'b01 : 2'b10);

    // Burst hold: master 0 keeps the bus for 4 beats while master 1 waits.
    doReset();
    applyStimulus(1'b0, 2'b11, 2'b11, '0, 1'b0, '0);
    #2;
    checkOutput("burst arbitration cycle gnt", gnt, 2'b00);
    step();
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b0, 2'b11, 2'b11, '0, 1'b1, '0);
      #2;
      checkOutput($sformatf("burst beat %0d gnt", b), gnt, 2'b01);
      checkOutput($sformatf("burst beat %0d ack", b), mAck, 2'b01);
      step();
    end
    applyStimulus(1'b0, 2'b10, 2'b10, '0, 1'b0, '0);
    #2;
    checkOutput("burst release gnt", gnt, 2'b01);
    step();
    applyStimulus(1'b0, 2'b10, 2'b10, '0, 1'b0, '0);
    #2;
    checkOutput("burst idle gap gnt", gnt, 2'b00);
    step();
    applyStimulus(1'b0, 2'b10, 2'b10, '0, 1'b0, '0);
    #2;
    checkOutput("burst next grant", gnt, 2'b10);
    step();

    // Reset during master 1's burst, then master 0 must win the next contest.
    doReset();
    applyStimulus(1'b0, 2'b10, 2'b10, 2'b10, 1'b0, '0);
    step();
    applyStimulus(1'b0, 2'b10, 2'b10, 2'b10, 1'b1, '0);
    #2;
    checkOutput("midreset burst gnt", gnt, 2'b10);
    step();
    applyStimulus(1'b1, 2'b10, 2'b10, 2'b10, 1'b1, '0);
    step();
    applyStimulus(1'b0, 2'b11, 2'b11, 2'b00, 1'b1, '0);
    #2;
    checkOutput("midreset outputs", {gnt, cycO, stbO, mAck, mErr}, '0);
    step();
    applyStimulus(1'b0, 2'b11, 2'b11, 2'b00, 1'b0, '0);
    #2;
    checkOutput("midreset next winner", gnt, 2'b01);
    step();

    // Stalled slave on master 0.
    doReset();
    begin
      int stbCount = 0;
      int errAt = 0;
      int errPulses = 0;
      bit errPrev = 0;
      logic [N-1:0] errSeen = '0;
      for (int c = 0; c < 30; c++) begin
        applyStimulus(1'b0, 2'b01, 2'b01, '0, 1'b0, '0);
        #2;
        if (stbO) stbCount++;
        if (errPrev) checkOutput("timeout cyc after err", {cycO, stbO, gnt}, {2'b00, 2'b01});
        errPrev = 1'b0;
        if (mErr != '0) begin
          errPulses++;
          errSeen = mErr;
          errAt = stbCount;
          errPrev = 1'b1;
        end
        step();
      end
`ifdef WB_ARB_TIMEOUT_EN
      checkOutput("timeout err pulses", errPulses, 1);
      checkOutput("timeout err vector", errSeen, 2'b01);
      checkOutput("timeout err stb cycle", errAt, TO);
      applyStimulus(1'b0, 2'b01, 2'b01, '0, 1'b1, '0);
      #2;
      checkOutput("abort hold", {gnt, cycO, mAck}, {2'b01, 1'b0, 2'b00});
      step();
`else
      checkOutput("no timeout err pulses", errPulses, 0);
      checkOutput("no timeout grant held", {gnt, cycO, stbO}, {2'b01, 2'b11});
`endif
      applyStimulus(1'b0, 2'b00, 2'b00, '0, 1'b0, '0);
      step();
      applyStimulus(1'b0, 2'b00, 2'b00, '0, 1'b0, '0);
      #2;
      checkOutput("stall release gnt", gnt, 2'b00);
      step();
    end

    // Randomized traffic against the model.
    doReset();
    modelReset();
    rCyc = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(3) == 0) rCyc[k] = ~rCyc[k];
        rStb[k] = rCyc[k] & ($urandom_range(3) != 0);
        rWe[k]  = 1'($urandom_range(1));
        adrArr[k] = AW'($urandom);
        datArr[k] = $urandom;
        selArr[k] = BW'($urandom);
      end
      applyStimulus(($urandom_range(60) == 0), rCyc, rStb, rWe, 1'($urandom_range(1)), $urandom);
      #2;
      modelOutputs();
      checkOutput($sformatf("rand %0d gnt", c), gnt, eGnt);
      checkOutput($sformatf("rand %0d ctl", c), {cycO, stbO, weO}, {eCyc, eStb, eWe});
      checkOutput($sformatf("rand %0d adr", c), adrO, eAdr);
      checkOutput($sformatf("rand %0d data", c), dataO, eDat);
      checkOutput($sformatf("rand %0d sel", c), selO, eSel);
      checkOutput($sformatf("rand %0d ack", c), mAck, eAck);
      checkOutput($sformatf("rand %0d err", c), mErr, eErr);
      checkOutput($sformatf("rand %0d rdata", c), mDataR, curDin);
      modelStep();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone arbiter that shares one Wishbone slave port, such as the Avalon-to-Wishbone bridge's peripheral side, between NUM_MASTERS Wishbone masters. It sits between the masters (CPU bridge, DMA, debug port) and the single slave bus. It grants one master per bus cycle and holds the grant for as long as that master keeps cyc asserted. It routes ack, and optionally a timeout error, back to the granted master only.

## Interface
Parameters:
- NUM_MASTERS, 2: number of requesting masters, 2..8.
- BUS_WIDTH, 5: address width.
- DATA_WIDTH, 32: data width.
- BE_WIDTH, 4: byte-select width.
- TIMEOUT_CYCLES, 16: stalled-strobe cycles before abort; only used with the timeout feature, minimum 2.

Ports:
- clk_i, in, 1: single clock.
- rst_i, in, 1: reset, synchronous, active-high.
- m_cyc_i, in, NUM_MASTERS: per-master cycle request.
- m_stb_i, in, NUM_MASTERS: per-master strobe.
- m_we_i, in, NUM_MASTERS: per-master write enable.
- m_adr_i, in, NUM_MASTERS*BUS_WIDTH: packed addresses, master k at [k*BUS_WIDTH +: BUS_WIDTH].
- m_data_i, in, NUM_MASTERS*DATA_WIDTH: packed write data.
- m_sel_i, in, NUM_MASTERS*BE_WIDTH: packed byte selects.
- m_data_o, out, DATA_WIDTH: read data, broadcast to all masters.
- m_ack_o, out, NUM_MASTERS: per-master ack.
- m_err_o, out, NUM_MASTERS: per-master error (timeout abort).
- gnt_o, out, NUM_MASTERS: one-hot current grant.
- cyc_o, stb_o, we_o, out, 1 each: slave control.
- adr_o, out, BUS_WIDTH: slave address.
- data_o, out, DATA_WIDTH: slave write data.
- sel_o, out, BE_WIDTH: slave byte select.
- data_i, in, DATA_WIDTH: slave read data.
- ack_i, in, 1: slave ack.

## Operation
States: IDLE, BUSY, and ABORT (ABORT exists only with the timeout feature).
- **IDLE**
  - Request vector: req = m_cyc_i & m_stb_i.
  - If req is nonzero, select the first set bit searching upward from last_grant+1, wrapping modulo NUM_MASTERS.
  - Register that index as g, set gnt_o to one-hot g, and go to BUSY.
  - All slave outputs are 0 while in IDLE.
- **BUSY**
  - Slave outputs are combinational muxes of master g: cyc_o = m_cyc_i[g], stb_o = m_stb_i[g], and we_o/adr_o/data_o/sel_o taken from master g's slice.
  - m_ack_o[g] = ack_i & m_stb_i[g]. All other ack bits are 0.
  - m_data_o = data_i in every state.
  - Multi-beat transfers: the grant holds while m_cyc_i[g] = 1.
  - When m_cyc_i[g] = 0: go to IDLE, set last_grant = g, clear gnt_o.
- **Timeout counter** (feature enabled)
  - Clears on entry to BUSY and whenever ack_i = 1 or stb_o = 0.
  - Otherwise increments each cycle.
  - On reaching TIMEOUT_CYCLES-1 with no ack that cycle: pulse m_err_o[g] for exactly one cycle, go to ABORT.
- **ABORT**
  - cyc_o/stb_o are forced to 0 and gnt_o stays one-hot g.
  - When m_cyc_i[g] = 0: go to IDLE, set last_grant = g.
- **Boundary cases**
  - ack_i while the granted master's stb is 0, or in IDLE/ABORT: ignored.
  - Masters that are not granted never see ack or err.
  - A requester that drops its request while waiting loses nothing; it is simply not chosen.
  - Simultaneous release and new request: the release cycle returns to IDLE, and arbitration happens in the following IDLE cycle.

## Timing
- **Reset values:** state = IDLE, last_grant = NUM_MASTERS-1 (so master 0 wins the first contest), counter = 0. Every output is 0, including m_data_o only if data_i = 0.
- **Grant latency:** a request sampled in IDLE at edge n gives gnt_o/cyc_o/stb_o at the granted master's values in cycle n+1.
- **Ack path:** ack is combinational from ack_i, with zero added latency.
- **Release to next grant:** m_cyc_i[g] low at edge n puts the arbiter in IDLE in cycle n+1. The next grant is visible in cycle n+2 at the earliest.
- **Timeout:** with a stalled strobe, m_err_o pulses TIMEOUT_CYCLES cycles after stb_o is first seen high. cyc_o falls in the following cycle.
- **Reset mid-transfer:** cyc_o/stb_o/gnt_o read 0 the cycle after rst_i is sampled high. No ack or err is issued for the killed transfer.

## Configuration
- **Macro:** WB_ARB_TIMEOUT_EN.
- **Defined:** the timeout counter, ABORT state and m_err_o logic are present.
- **Undefined:**
  - No counter and no ABORT state.
  - m_err_o is tied to 0.
  - A never-acking slave holds the grant indefinitely.
  - TIMEOUT_CYCLES is ignored.

## Structure
- **Package wb_arb_pkg:**
  - State enum arb_state_t {IDLE, BUSY, ABORT}.
  - Function for grant index width: $clog2(NUM_MASTERS), minimum 1.
  - Slice-extraction helper for the packed master buses.
- **Sub-module rr_priority_encoder:** combinational.
  - Inputs: req vector and last_grant index.
  - Outputs: next index and a valid flag.
  - Reusable by future schedulers.

## Test plan
- **Single master:** NUM_MASTERS = 2; master 1 writes adr 5'h0A, data 32'hDEADBEEF, sel 4'hF; slave acks one cycle later.
  - Slave sees exactly those values from cycle n+1.
  - m_ack_o = 2'b10 for one cycle; m_ack_o[0] is never set.
- **Contention fairness:** both masters hold requests from reset, each cycle being one transfer.
  - Grants alternate 0, 1, 0, 1.
  - One IDLE cycle separates each grant.
- **Burst hold:** master 0 keeps cyc high for 4 acked beats while master 1 requests.
  - gnt_o stays 2'b01 for all 4 beats.
  - Master 1 is granted 2 cycles after master 0 drops cyc.
- **Timeout:** macro defined, TIMEOUT_CYCLES = 16, slave never acks master 0.
  - m_err_o = 2'b01 pulses once, 16 cycles after stb_o rises.
  - cyc_o is 0 the next cycle and the arbiter waits in ABORT until m_cyc_i[0] falls.
- **Mid-burst reset:** assert rst_i during master 1's burst.
  - All outputs are 0 the next cycle.
  - After release, master 0 wins the next contest with master 1.
- **Stray ack:** ack_i pulsed in IDLE and while the granted master's stb is 0.
  - All m_ack_o bits stay 0.
